// File: rtl/alu_ir_core.sv
// alu_ir_core: registered 16-bit ALU with Z/Y flags plus the instruction register
module alu_ir_core #(
   parameter int DATA_W  = 16,
   parameter int OPC_W   = 4,
   parameter int WRDEC_W = 20,
   parameter int IR_SEL  = 19
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic [DATA_W-1:0]  In_1,
   input  logic [DATA_W-1:0]  In_2,
   input  logic [OPC_W-1:0]   ALUOp,
   output logic [DATA_W-1:0]  ALUOut,
   output logic               Z,
   output logic               Y,
   input  logic [WRDEC_W-1:0] WRDec_out,
   input  logic [DATA_W-1:0]  MIDR_out,
   output logic [OPC_W-1:0]   IR_out
);
   localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_INC   = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_PASSB = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_CLR   = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_CMP   = OPC_W'(8);

   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     diff;
   logic [DATA_W:0]     inc;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   nxt_out;
   logic                nxt_z;
   logic                nxt_y;
   logic                writes_out;
   logic [DATA_W-1:0]   ir;
   logic                unused_bits;

   // bit DATA_W of the widened sum/difference is the carry/borrow
   assign sum  = {1'b0, In_1} + {1'b0, In_2};
   assign diff = {1'b0, In_1} - {1'b0, In_2};
   assign inc  = {1'b0, In_1} + (DATA_W+1)'(1);
   assign prod = {{DATA_W{1'b0}}, In_1} * {{DATA_W{1'b0}}, In_2};

   // next result and flags; unlisted opcodes (NOP/reserved) hold everything
   always_comb begin
      nxt_out    = ALUOut;
      nxt_y      = Y;
      writes_out = 1'b1;
      nxt_z      = Z;
      case (ALUOp)
         OP_ADD:   begin nxt_out = sum[DATA_W-1:0];  nxt_y = sum[DATA_W];  end
         OP_SUB:   begin nxt_out = diff[DATA_W-1:0]; nxt_y = diff[DATA_W]; end
         OP_MUL:   begin nxt_out = prod[DATA_W-1:0]; nxt_y = |prod[2*DATA_W-1:DATA_W]; end
         OP_INC:   begin nxt_out = inc[DATA_W-1:0];  nxt_y = inc[DATA_W];  end
         OP_PASSB: begin nxt_out = In_2;             nxt_y = 1'b0;         end
         OP_CLR:   begin nxt_out = '0;               nxt_y = 1'b0;         end
         OP_CMP:   begin writes_out = 1'b0; nxt_z = (In_1 == In_2); nxt_y = (In_1 < In_2); end
         default:  writes_out = 1'b0;
      endcase
      if (writes_out) nxt_z = (nxt_out == '0);
   end

   // ALU result and flag registers
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         ALUOut <= '0;
         Z      <= 1'b0;
         Y      <= 1'b0;
      end else begin
         ALUOut <= nxt_out;
         Z      <= nxt_z;
         Y      <= nxt_y;
      end
   end

   // instruction register loads only on its own write-decoder select bit
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) ir <= '0;
      else if (WRDec_out[IR_SEL]) ir <= MIDR_out;
   end

   assign IR_out = ir[DATA_W-1:DATA_W-OPC_W];

   // the low IR bits and the other decoder selects are not consumed here
   assign unused_bits = ^{WRDec_out, ir[DATA_W-OPC_W-1:0]};
endmodule

// File: tb/tb_alu_ir_core.sv
// tb_alu_ir_core: table-driven and directed checks of the ALU and IR
module tb_alu_ir_core;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_1, in_2;
   logic [3:0]  alu_op;
   logic [15:0] alu_out;
   logic        z, y;
   logic [19:0] wr_dec;
   logic [15:0] midr;
   logic [3:0]  ir_out;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] e_out;
      logic        e_z;
      logic        e_y;
   } vec_t;

   vec_t v[19];

   alu_ir_core dut (
      .Clock(clk), .Reset_n(rst_n), .In_1(in_1), .In_2(in_2), .ALUOp(alu_op),
      .ALUOut(alu_out), .Z(z), .Y(y), .WRDec_out(wr_dec), .MIDR_out(midr),
      .IR_out(ir_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [19:0] wr, input logic [15:0] m);
      @(negedge clk);
      alu_op = op; in_1 = a; in_2 = b; wr_dec = wr; midr = m;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_alu(input string name, input logic [15:0] o, input logic ez, input logic ey);
      chk({name, " out"}, 32'(alu_out), 32'(o));
      chk({name, " z"}, 32'(z), 32'(ez));
      chk({name, " y"}, 32'(y), 32'(ey));
   endtask

   initial begin
      v[0]  = '{4'd1,  16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
      v[1]  = '{4'd2,  16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
      v[2]  = '{4'd3,  16'h0005, 16'h0003, 16'h000F, 1'b0, 1'b0};
      v[3]  = '{4'd4,  16'h0005, 16'h0003, 16'h0006, 1'b0, 1'b0};
      v[4]  = '{4'd5,  16'h0005, 16'h0003, 16'h0003, 1'b0, 1'b0};
      v[5]  = '{4'd7,  16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0};
      v[6]  = '{4'd8,  16'h0005, 16'h0003, 16'h0000, 1'b0, 1'b0};
      v[7]  = '{4'd1,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
      v[8]  = '{4'd2,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1};
      v[9]  = '{4'd3,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1};
      v[10] = '{4'd1,  16'h0000, 16'h0008, 16'h0008, 1'b0, 1'b0};
      v[11] = '{4'd0,  16'h1234, 16'h4321, 16'h0008, 1'b0, 1'b0};
      v[12] = '{4'd6,  16'hFFFF, 16'hFFFF, 16'h0008, 1'b0, 1'b0};
      v[13] = '{4'd15, 16'h0000, 16'h0000, 16'h0008, 1'b0, 1'b0};
      v[14] = '{4'd8,  16'h0007, 16'h0007, 16'h0008, 1'b1, 1'b0};
      v[15] = '{4'd9,  16'h0001, 16'h0002, 16'h0008, 1'b1, 1'b0};
      v[16] = '{4'd8,  16'h0002, 16'h0009, 16'h0008, 1'b0, 1'b1};
      v[17] = '{4'd4,  16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
      v[18] = '{4'd5,  16'h1111, 16'h0000, 16'h0000, 1'b1, 1'b0};

      rst_n = 1'b0; alu_op = 4'd1; in_1 = 16'h0005; in_2 = 16'h0003;
      wr_dec = 20'h80000; midr = 16'hF000;
      #2;
      chk_alu("reset", 16'h0000, 1'b0, 1'b0);
      chk("reset ir", 32'(ir_out), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk_alu("reset held", 16'h0000, 1'b0, 1'b0);
      chk("reset held ir", 32'(ir_out), 32'h0);
      @(negedge clk);
      wr_dec = 20'h0;
      rst_n = 1'b1;
      #1;
      chk_alu("release pre-edge", 16'h0000, 1'b0, 1'b0);

      for (int i = 0; i < 19; i++) begin
         step(v[i].op, v[i].a, v[i].b, 20'h0, 16'h0000);
         chk_alu($sformatf("vec%0d op%0d", i, v[i].op), v[i].e_out, v[i].e_z, v[i].e_y);
      end

      step(4'd0, 16'h0, 16'h0, 20'h00000, 16'h5555);
      chk("ir no sel", 32'(ir_out), 32'h0);
      step(4'd0, 16'h0, 16'h0, 20'h80000, 16'h5555);
      chk("ir load", 32'(ir_out), 32'h5);
      step(4'd0, 16'h0, 16'h0, 20'hFFFFF, 16'h0000);
      chk("ir all sel", 32'(ir_out), 32'h0);
      step(4'd0, 16'h0, 16'h0, 20'h00000, 16'h5555);
      chk("ir hold", 32'(ir_out), 32'h0);
      step(4'd0, 16'h0, 16'h0, 20'h7FFFF, 16'hA000);
      chk("ir other sels", 32'(ir_out), 32'h0);
      chk_alu("alu idle during ir", 16'h0000, 1'b1, 1'b0);

      step(4'd1, 16'h0001, 16'h0002, 20'h80000, 16'hC000);
      chk_alu("concurrent add", 16'h0003, 1'b0, 1'b0);
      chk("concurrent ir", 32'(ir_out), 32'hC);

      @(negedge clk);
      alu_op = 4'd1; in_1 = 16'h0005; in_2 = 16'h0003; wr_dec = 20'h80000; midr = 16'h9000;
      #1 rst_n = 1'b0;
      #1;
      chk_alu("mid reset", 16'h0000, 1'b0, 1'b0);
      chk("mid reset ir", 32'(ir_out), 32'h0);
      #1 rst_n = 1'b1;
      #1;
      chk_alu("mid release pre-edge", 16'h0000, 1'b0, 1'b0);
      chk("mid release ir", 32'(ir_out), 32'h0);
      @(posedge clk);
      #1;
      chk_alu("after reset add", 16'h0008, 1'b0, 1'b0);
      chk("after reset ir", 32'(ir_out), 32'h9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
